mult_sweep_driver: RTL and testbench
====================================

# mult_sweep_driver

Upstream operand sequencer and downstream result checker for the multiplier stage. It walks every operand pair of a WIDTH-bit multiplier exhaustively and drives the multiplier's operand/start inputs. It collects each product, compares it with an internally computed golden product, and reports pass/fail status. The block wraps a single multiplier instance for self-test of the Trachtenberg and simple multiplier variants.

## Interface
- WIDTH, 5, operand width; must match the multiplier under test
- RES_DLY, 1, cycles between sampling ivalid high and sampling ires (0..3)
- TIMEOUT, 15, maximum WAIT cycles before a pair is declared failed (used only with the timeout macro)
- ERR_W, 16, width of the error counter
- iclk  in  1  clock, all state on rising edge
- irst  in  1  reset, asynchronous, active-high
- igo  in  1  start sweep; sampled in IDLE/DONE only
- oa  out  WIDTH  operand A to the multiplier ia
- ob  out  WIDTH  operand B to the multiplier ib
- ostart  out  1  one-cycle start pulse to the multiplier istart
- ires  in  2*WIDTH  product from the multiplier ores
- ivalid  in  1  valid from the multiplier ovalid
- obusy  out  1  high from ISSUE of the first pair until DONE
- odone  out  1  level, high in DONE until the next igo
- oerr_cnt  out  ERR_W  mismatches plus timeouts, saturating
- ofail  out  1  sticky, set on the first error
- ofirst_a  out  WIDTH  oa of the first failing pair
- ofirst_b  out  WIDTH  ob of the first failing pair

## Operation
- FSM states: IDLE, ISSUE, WAIT, SETTLE, CHECK, DONE.
- IDLE/DONE + igo:
  - clear oerr_cnt, ofail, ofirst_*
  - oa=ob=0
  - go to ISSUE
- ISSUE:
  - ostart=1 for exactly this cycle
  - go to WAIT
- WAIT:
  - ivalid sampled high → SETTLE, or → CHECK if RES_DLY=0
  - otherwise stay in WAIT
- SETTLE: count RES_DLY cycles, then go to CHECK.
- CHECK:
  - compare ires against oa*ob, computed at full 2*WIDTH width with no truncation
  - on mismatch: oerr_cnt+1, saturating at 2^ERR_W-1; ofail=1
  - if ofail was 0 before this error, also capture ofirst_a/ofirst_b
- Advance after CHECK:
  - ob increments fastest
  - ob wraps from 2^WIDTH-1 to 0 and oa increments
  - if the checked pair was oa=ob=2^WIDTH-1, go to DONE; otherwise go to ISSUE
- oa/ob are held stable from ISSUE through CHECK of each pair.
- ivalid outside WAIT is ignored. igo outside IDLE/DONE is ignored.
- Reset, including mid-sweep:
  - every output and all state go to 0 immediately
  - FSM goes to IDLE
  - the next sweep restarts at (0,0)
- Reset values: oa=0, ob=0, ostart=0, obusy=0, odone=0, oerr_cnt=0, ofail=0, ofirst_a=0, ofirst_b=0.

## Timing
- igo is sampled at edge E0; ostart is high during cycle E0..E0+1.
- With a multiplier whose ivalid rises one cycle after ostart and RES_DLY=1, each pair takes 4 cycles: ISSUE, WAIT, SETTLE, CHECK.
- For that multiplier, odone rises at edge E0+4·2^(2·WIDTH). For WIDTH=5 this is E0+4096.
- RES_DLY=1 covers a multiplier whose product settles one cycle after its valid.
- Per-pair latency is 3+RES_DLY+(extra WAIT cycles).
- obusy and odone are never high together.

## Configuration
- MULT_SWEEP_TIMEOUT_EN defined:
  - a counter runs in WAIT
  - after TIMEOUT cycles without ivalid, the pair is treated as a CHECK mismatch: error count, sticky fail, first capture
  - the sweep then advances without a CHECK compare
- Macro undefined:
  - WAIT holds indefinitely; obusy stays 1 if ivalid never arrives
  - TIMEOUT is unused and no counter logic is generated

## Structure
- Shared package mult_pkg holds:
  - the FSM state enum typedef
  - the state encoding
  - default WIDTH/ERR_W constants used by the multiplier stages
- One sub-module: mult_operand_counter, the nested oa/ob counter.
  - Inputs: clear, advance.
  - Outputs: oa, ob, last flag (both operands at all-ones).

## Test plan
- Ideal model, WIDTH=5, RES_DLY=1, ivalid one cycle after ostart, product one cycle later; pulse igo → odone at E0+4096, oerr_cnt=0, ofail=0, exactly 1024 ostart pulses.
- Fault model returns 22 for (3,7) and 0 for (31,31) → oerr_cnt=2, ofail=1, ofirst_a=3, ofirst_b=7.
- Timeout, model never asserts ivalid for (0,5):
  - macro defined, TIMEOUT=15 → WAIT exits after 15 cycles, oerr_cnt=1, ofirst=(0,5), sweep completes
  - macro undefined → obusy stays 1 and oa=0, ob=5 indefinitely
- igo pulsed mid-sweep → ignored, no counter clear. igo in DONE → counters clear and a new sweep starts from (0,0).
- irst asserted at pair (2,9) in SETTLE → all outputs 0 before the next edge; after release, igo restarts with oa=0, ob=0.
- ERR_W=4, model always wrong → oerr_cnt saturates at 15; ofirst=(0,0); odone still rises.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier self-test stages.
//   - sweep_state_e : FSM state encoding of the operand sweep driver
//   - MULT_WIDTH    : default operand width of the multiplier stages
//   - MULT_ERR_W    : default width of the error counter
//   - st_busy()     : true for states between issuing a pair and checking it
package mult_pkg;

    localparam int MULT_WIDTH = 5;
    localparam int MULT_ERR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } sweep_state_e;

    function automatic logic st_busy(input sweep_state_e st);
        return (st == ST_ISSUE) || (st == ST_WAIT) ||
               (st == ST_SETTLE) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/mult_sweep_driver_if.sv
// Operand/result bus between the sweep driver and the multiplier under test.
//   oa, ob  : operands towards the multiplier
//   ostart  : one-cycle start pulse towards the multiplier
//   ires    : product from the multiplier (2*WIDTH bits)
//   ivalid  : product-valid from the multiplier
// Modports: master = sweep driver side, slave = multiplier side.
interface mult_sweep_driver_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic [WIDTH-1:0]   oa;
    logic [WIDTH-1:0]   ob;
    logic               ostart;
    logic [2*WIDTH-1:0] ires;
    logic               ivalid;

    modport master (output oa, output ob, output ostart, input ires, input ivalid);
    modport slave  (input oa, input ob, input ostart, output ires, output ivalid);
endinterface

// File: rtl/mult_operand_counter.sv
// Nested operand counter: ob is the fast digit, oa the slow digit.
//   iclk, irst : clock, asynchronous active-high reset
//   iclear     : load (0,0)
//   iadvance   : step to the next operand pair
//   oa, ob     : current pair (registered)
//   olast      : both operands at all-ones
module mult_operand_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             iclear,
    input  logic             iadvance,
    output logic [WIDTH-1:0] oa,
    output logic [WIDTH-1:0] ob,
    output logic             olast
);
    localparam logic [WIDTH-1:0] OP_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OP_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    // Operand pair register: clear wins over advance, ob carries into oa.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            a_r <= OP_ZERO;
            b_r <= OP_ZERO;
        end else if (iclear) begin
            a_r <= OP_ZERO;
            b_r <= OP_ZERO;
        end else if (iadvance) begin
            if (b_r == OP_MAX) begin
                b_r <= OP_ZERO;
                a_r <= a_r + WIDTH'(1);
            end else begin
                b_r <= b_r + WIDTH'(1);
            end
        end
    end

    assign oa    = a_r;
    assign ob    = b_r;
    assign olast = (a_r == OP_MAX) && (b_r == OP_MAX);

endmodule

// File: rtl/mult_sweep_driver.sv
// Exhaustive operand sweep driver and result checker for a WIDTH-bit
// multiplier. Issues every (a,b) pair, compares each product with a*b and
// accumulates a saturating error count plus the first failing pair.
//   iclk, irst        : clock, asynchronous active-high reset
//   igo               : start a sweep (accepted in IDLE/DONE only)
//   mif (master)      : oa/ob/ostart out, ires/ivalid in
//   obusy, odone      : sweep in progress / sweep finished (level)
//   oerr_cnt, ofail   : saturating error count, sticky fail flag
//   ofirst_a/ofirst_b : operands of the first failing pair
// Optional build macro MULT_SWEEP_TIMEOUT_EN: a pair whose ivalid does not
// arrive within TIMEOUT WAIT cycles is counted as an error and skipped.
module mult_sweep_driver
    import mult_pkg::*;
#(
    parameter int WIDTH   = MULT_WIDTH,
    parameter int RES_DLY = 1,
    parameter int TIMEOUT = 15,
    parameter int ERR_W   = MULT_ERR_W
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               igo,
    mult_sweep_driver_if.master mif,
    output logic               obusy,
    output logic               odone,
    output logic [ERR_W-1:0]   oerr_cnt,
    output logic               ofail,
    output logic [WIDTH-1:0]   ofirst_a,
    output logic [WIDTH-1:0]   ofirst_b
);
    localparam logic [1:0]       SETTLE_LAST = (RES_DLY > 0) ? 2'(RES_DLY - 1) : 2'd0;
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    if ((RES_DLY < 0) || (RES_DLY > 3) || (TIMEOUT < 1) || (ERR_W < 1)) begin : g_bad_param
        $error("mult_sweep_driver: parameter out of range");
    end

    sweep_state_e       state_r;
    sweep_state_e       state_s;
    logic [1:0]         dly_r;
    logic [2*WIDTH-1:0] res_r;
    logic [2*WIDTH-1:0] prod_s;
    logic               go_s;
    logic               cap_s;
    logic               mismatch_s;
    logic               last_s;
    logic               to_expire_s;
    logic               to_hit_s;
    logic               ostart_r;
    logic               obusy_r;
    logic               odone_r;
    logic [ERR_W-1:0]   err_cnt_r;
    logic               fail_r;
    logic [WIDTH-1:0]   first_a_r;
    logic [WIDTH-1:0]   first_b_r;

    mult_operand_counter #(.WIDTH(WIDTH)) u_cnt (
        .iclk     (iclk),
        .irst     (irst),
        .iclear   (go_s),
        .iadvance (state_r == ST_CHECK),
        .oa       (mif.oa),
        .ob       (mif.ob),
        .olast    (last_s)
    );

`ifdef MULT_SWEEP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            to_hit_r;

    assign to_expire_s = (state_r == ST_WAIT) && !mif.ivalid &&
                         (to_cnt_r == TO_W'(TIMEOUT - 1));
    assign to_hit_s    = to_hit_r;

    // WAIT watchdog; the hit flag marks the following CHECK as a forced error.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            to_cnt_r <= {TO_W{1'b0}};
            to_hit_r <= 1'b0;
        end else begin
            to_cnt_r <= (state_r == ST_WAIT) ? to_cnt_r + TO_W'(1) : {TO_W{1'b0}};
            if (to_expire_s) begin
                to_hit_r <= 1'b1;
            end else if (state_r == ST_CHECK) begin
                to_hit_r <= 1'b0;
            end
        end
    end
`else
    assign to_expire_s = 1'b0;
    assign to_hit_s    = 1'b0;
`endif

    assign go_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && igo;
    // Product is captured on the edge that enters CHECK, RES_DLY edges after ivalid.
    assign cap_s  = (state_s == ST_CHECK) &&
                    ((state_r == ST_WAIT) || (state_r == ST_SETTLE));
    assign prod_s = (2*WIDTH)'(mif.oa) * (2*WIDTH)'(mif.ob);
    assign mismatch_s = to_hit_s || (res_r != prod_s);

    // Next-state logic of the sweep FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (igo) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (mif.ivalid) begin
                    state_s = (RES_DLY == 0) ? ST_CHECK : ST_SETTLE;
                end else if (to_expire_s) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (dly_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, settle counter and product capture.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_r <= ST_IDLE;
            dly_r   <= 2'd0;
            res_r   <= {(2*WIDTH){1'b0}};
        end else begin
            state_r <= state_s;
            dly_r   <= (state_r == ST_SETTLE) ? dly_r + 2'd1 : 2'd0;
            if (cap_s) begin
                res_r <= mif.ires;
            end
        end
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            ostart_r <= 1'b0;
            obusy_r  <= 1'b0;
            odone_r  <= 1'b0;
        end else begin
            ostart_r <= (state_s == ST_ISSUE);
            obusy_r  <= st_busy(state_s);
            odone_r  <= (state_s == ST_DONE);
        end
    end

    // Error bookkeeping: cleared on an accepted igo, updated at the end of CHECK.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            err_cnt_r <= {ERR_W{1'b0}};
            fail_r    <= 1'b0;
            first_a_r <= {WIDTH{1'b0}};
            first_b_r <= {WIDTH{1'b0}};
        end else if (go_s) begin
            err_cnt_r <= {ERR_W{1'b0}};
            fail_r    <= 1'b0;
            first_a_r <= {WIDTH{1'b0}};
            first_b_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_CHECK) && mismatch_s) begin
            if (err_cnt_r != ERR_MAX) begin
                err_cnt_r <= err_cnt_r + ERR_W'(1);
            end
            fail_r <= 1'b1;
            if (!fail_r) begin
                first_a_r <= mif.oa;
                first_b_r <= mif.ob;
            end
        end
    end

    assign mif.ostart = ostart_r;
    assign obusy      = obusy_r;
    assign odone      = odone_r;
    assign oerr_cnt   = err_cnt_r;
    assign ofail      = fail_r;
    assign ofirst_a   = first_a_r;
    assign ofirst_b   = first_b_r;

endmodule

// File: tb/tb_mult_sweep_driver.sv
// Self-checking bench for mult_sweep_driver: a behavioural multiplier with
// programmable wrong products, latency and a stalled pair, plus a reference
// model that tracks the expected pair order and error bookkeeping.
module tb_mult_sweep_driver;
    localparam int W     = 5;
    localparam int N     = 1 << W;
    localparam int NP    = N * N;
    localparam int ERR_W = 16;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    logic igo  = 1'b0;
    logic igo4 = 1'b0;
    always #5 iclk = ~iclk;

    mult_sweep_driver_if #(.WIDTH(W)) mif ();
    mult_sweep_driver_if #(.WIDTH(W)) mif4 ();

    logic             obusy, odone, ofail;
    logic [ERR_W-1:0] oerr_cnt;
    logic [W-1:0]     ofirst_a, ofirst_b;
    logic             obusy4, odone4, ofail4;
    logic [3:0]       oerr_cnt4;
    logic [W-1:0]     ofirst_a4, ofirst_b4;

    mult_sweep_driver #(.WIDTH(W), .RES_DLY(1), .TIMEOUT(15), .ERR_W(ERR_W)) u_dut (
        .iclk(iclk), .irst(irst), .igo(igo), .mif(mif),
        .obusy(obusy), .odone(odone), .oerr_cnt(oerr_cnt), .ofail(ofail),
        .ofirst_a(ofirst_a), .ofirst_b(ofirst_b)
    );

    mult_sweep_driver #(.WIDTH(W), .RES_DLY(1), .TIMEOUT(15), .ERR_W(4)) u_dut4 (
        .iclk(iclk), .irst(irst), .igo(igo4), .mif(mif4),
        .obusy(obusy4), .odone(odone4), .oerr_cnt(oerr_cnt4), .ofail(ofail4),
        .ofirst_a(ofirst_a4), .ofirst_b(ofirst_b4)
    );

`ifdef MULT_SWEEP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge iclk) cyc <= cyc + 1;

    // ---------------- behavioural multiplier ----------------
    logic            ovr     [NP];
    logic [2*W-1:0]  ovr_val [NP];
    int              stall_k  = -1;
    bit              lat_rand = 1'b0;
    int              lat_cnt  = 0;
    logic [W-1:0]    ca, cb;

    function automatic logic [2*W-1:0] mul_model(input int a, input int b);
        if (ovr[a*N+b]) return ovr_val[a*N+b];
        return (2*W)'(a * b);
    endfunction

    initial mif.ires = '0;
    always @(posedge iclk) begin
        if (mif.ostart) begin
            ca <= mif.oa;
            cb <= mif.ob;
            if (int'(mif.oa) * N + int'(mif.ob) == stall_k) lat_cnt <= 0;
            else lat_cnt <= lat_rand ? int'($urandom_range(1, 3)) : 1;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
        if (lat_cnt == 1) mif.ires <= mul_model(int'(ca), int'(cb));
    end
    assign mif.ivalid = (lat_cnt == 1);

    // Always-wrong multiplier for the narrow-counter instance.
    logic v4 = 1'b0;
    initial mif4.ires = '0;
    always @(posedge iclk) begin
        v4 <= mif4.ostart;
        if (v4) mif4.ires <= (2*W)'(int'(mif4.oa) * int'(mif4.ob) + 1);
    end
    assign mif4.ivalid = v4;

    // ---------------- reference model + compare process ----------------
    int m_k = 0, m_err = 0, m_fa = 0, m_fb = 0, cur_a = 0, cur_b = 0;
    bit m_fail = 0, m_pend = 0, m_pend_bad = 0;
    bit prev_busy = 0, prev_start = 0, prev_done = 0;

    function automatic bit pair_bad(input int a, input int b);
        if (a * N + b == stall_k) return TO_EN;
        return mul_model(a, b) != (2*W)'(a * b);
    endfunction

    task automatic commit();
        if (m_pend && m_pend_bad) begin
            if (m_err < (1 << ERR_W) - 1) m_err++;
            if (!m_fail) begin m_fa = cur_a; m_fb = cur_b; end
            m_fail = 1'b1;
        end
        m_pend = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_err"},   oerr_cnt, m_err);
        chk({tag, "_fail"},  ofail,    m_fail);
        chk({tag, "_first_a"}, ofirst_a, m_fa);
        chk({tag, "_first_b"}, ofirst_b, m_fb);
    endtask

    always @(negedge iclk) begin
        if (irst) begin
            m_k = 0; m_err = 0; m_fail = 0; m_fa = 0; m_fb = 0; m_pend = 0;
            prev_busy = 0; prev_start = 0; prev_done = 0;
        end else begin
            chk("busy_done_excl", obusy & odone, 0);
            if (mif.ostart) begin
                chk("start_pulse", prev_start, 0);
                if (!prev_busy) begin
                    m_k = 0; m_err = 0; m_fail = 0; m_fa = 0; m_fb = 0; m_pend = 0;
                end else begin
                    commit();
                end
                chk("issue_a", mif.oa, m_k / N);
                chk("issue_b", mif.ob, m_k % N);
                chk_status("issue");
                cur_a = m_k / N;
                cur_b = m_k % N;
                m_pend = 1'b1;
                m_pend_bad = pair_bad(cur_a, cur_b);
                m_k++;
            end else if (obusy) begin
                chk("hold_a", mif.oa, cur_a);
                chk("hold_b", mif.ob, cur_b);
            end
            if (odone && !prev_done) begin
                commit();
                chk("sweep_pairs", m_k, NP);
                chk_status("done");
            end
            prev_busy  = obusy;
            prev_start = mif.ostart;
            prev_done  = odone;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic pulse_go(output int e0);
        igo = 1'b1;
        @(negedge iclk);
        igo = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge iclk);
            if (odone) begin at = cyc; break; end
        end
        if (at < 0) chk("done_timeout", odone, 1);
    endtask

    task automatic wait_start(input int a, input int b, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge iclk);
            if (mif.ostart && mif.oa == W'(a) && mif.ob == W'(b)) begin at = cyc; break; end
        end
        if (at < 0) chk("start_timeout", mif.ostart, 1);
    endtask

    initial begin
        int e0, at, at2, exp_err, exp_fa, exp_fb, k;
        bit exp_fail;
        for (int i = 0; i < NP; i++) begin ovr[i] = 1'b0; ovr_val[i] = '0; end

        // Reset values
        tick(3);
        chk("rst_oa", mif.oa, 0);       chk("rst_ob", mif.ob, 0);
        chk("rst_ostart", mif.ostart, 0); chk("rst_busy", obusy, 0);
        chk("rst_done", odone, 0);      chk("rst_err", oerr_cnt, 0);
        chk("rst_fail", ofail, 0);      chk("rst_fa", ofirst_a, 0);
        chk("rst_fb", ofirst_b, 0);
        irst = 1'b0;
        tick(2);

        // Ideal sweep; narrow-counter instance runs alongside with an always-wrong multiplier
        igo = 1'b1; igo4 = 1'b1;
        @(negedge iclk);
        igo = 1'b0; igo4 = 1'b0;
        e0 = cyc;
        wait_done(6000, at);
        chk("ideal_done_edge", at - e0, 4096);
        chk("ideal_starts", m_k, 1024);
        chk("ideal_err", oerr_cnt, 0);
        chk("ideal_fail", ofail, 0);
        tick(2);
        chk("sat_done", odone4, 1);
        chk("sat_err", oerr_cnt4, 15);
        chk("sat_fail", ofail4, 1);
        chk("sat_first_a", ofirst_a4, 0);
        chk("sat_first_b", ofirst_b4, 0);
        chk("done_holds", odone, 1);

        // Fault sweep, started from DONE
        ovr[3*N+7] = 1'b1;   ovr_val[3*N+7] = 10'd22;
        ovr[NP-1]  = 1'b1;   ovr_val[NP-1]  = 10'd0;
        pulse_go(e0);
        wait_done(6000, at);
        chk("fault_err", oerr_cnt, 2);
        chk("fault_fail", ofail, 1);
        chk("fault_first_a", ofirst_a, 3);
        chk("fault_first_b", ofirst_b, 7);

        // Random wrong products and random multiplier latency, igo pulsed mid-sweep
        for (int i = 0; i < NP; i++) ovr[i] = 1'b0;
        repeat (6) begin
            k = int'($urandom_range(0, NP - 1));
            ovr[k] = 1'b1;
            ovr_val[k] = (2*W)'($urandom);
        end
        lat_rand = 1'b1;
        pulse_go(e0);
        tick(1500);
        igo = 1'b1;
        @(negedge iclk);
        igo = 1'b0;
        wait_done(20000, at);
        exp_err = 0; exp_fail = 0; exp_fa = 0; exp_fb = 0;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                if (mul_model(a, b) != (2*W)'(a * b)) begin
                    if (!exp_fail) begin exp_fa = a; exp_fb = b; end
                    exp_fail = 1'b1;
                    exp_err++;
                end
        chk("rand_err", oerr_cnt, exp_err);
        chk("rand_fail", ofail, exp_fail);
        chk("rand_first_a", ofirst_a, exp_fa);
        chk("rand_first_b", ofirst_b, exp_fb);

        // Reset in SETTLE of pair (2,9)
        for (int i = 0; i < NP; i++) ovr[i] = 1'b0;
        lat_rand = 1'b0;
        pulse_go(e0);
        wait_start(2, 9, 1000, at);
        tick(2);
        irst = 1'b1;
        #1;
        chk("mrst_oa", mif.oa, 0);        chk("mrst_ob", mif.ob, 0);
        chk("mrst_ostart", mif.ostart, 0); chk("mrst_busy", obusy, 0);
        chk("mrst_done", odone, 0);       chk("mrst_err", oerr_cnt, 0);
        chk("mrst_fail", ofail, 0);       chk("mrst_fa", ofirst_a, 0);
        chk("mrst_fb", ofirst_b, 0);
        @(negedge iclk);
        irst = 1'b0;
        tick(2);

        // Restart from (0,0) with pair (0,5) never answered
        stall_k = 5;
        pulse_go(e0);
        chk("restart_start", mif.ostart, 1);
        chk("restart_a", mif.oa, 0);
        chk("restart_b", mif.ob, 0);
        wait_start(0, 5, 200, at);
`ifdef MULT_SWEEP_TIMEOUT_EN
        wait_start(0, 6, 200, at2);
        chk("timeout_gap", at2 - at, 17);
        wait_done(6000, at);
        chk("timeout_err", oerr_cnt, 1);
        chk("timeout_fail", ofail, 1);
        chk("timeout_first_a", ofirst_a, 0);
        chk("timeout_first_b", ofirst_b, 5);
`else
        at2 = 0;
        for (int i = 0; i < 4; i++) begin
            tick(50);
            chk("stall_busy", obusy, 1);
            chk("stall_a", mif.oa, 0);
            chk("stall_b", mif.ob, 5);
            if (odone) at2++;
        end
        chk("stall_no_done", at2, 0);
        irst = 1'b1;
        tick(2);
        irst = 1'b0;
        tick(2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
